// File: rtl/jstk_poll_sched.sv
// Round-robin poll scheduler for several PmodJSTK joysticks sharing one SPI master.
// Drives per-slave select, trigger and command byte, then decodes each returned 40-bit packet.
module jstk_poll_sched #(
  parameter int N_SLAVES     = 2,
  parameter int POLL_CYCLES  = 500000,
  parameter int SETUP_CYCLES = 1500,
  parameter int TRIG_CYCLES  = 3000,
  parameter int XFER_CYCLES  = 150000,
  parameter int GAP_CYCLES   = 1500
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic [2*N_SLAVES-1:0]   led,
  input  logic [N_SLAVES-1:0]     miso_in,
  input  logic [39:0]             jstk_dout,
  output logic                    miso_out,
  output logic [N_SLAVES-1:0]     ss_n,
  output logic                    snd_rec,
  output logic [7:0]              din,
  output logic [10*N_SLAVES-1:0]  x_pos,
  output logic [10*N_SLAVES-1:0]  y_pos,
  output logic [3*N_SLAVES-1:0]   btn,
  output logic [N_SLAVES-1:0]     upd,
  output logic [N_SLAVES-1:0]     err
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int DMAX  = max4(SETUP_CYCLES, TRIG_CYCLES, XFER_CYCLES, GAP_CYCLES);
  localparam int CW    = ($clog2(DMAX) < 1) ? 1 : $clog2(DMAX);
  localparam int PW    = ($clog2(POLL_CYCLES) < 1) ? 1 : $clog2(POLL_CYCLES);
  localparam int CUR_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_TRIG    = 3'd2;
  localparam logic [2:0] S_XFER    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  logic [2:0]          state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [CUR_W-1:0]    cur_reg;
  logic [PW-1:0]       poll_reg;
  logic                poll_exp;
  logic                cnt_zero;
  logic                last_slot;
  logic [CUR_W-1:0]    cur_next;
  logic [7:0]          din_next;
  logic [N_SLAVES-1:0] ss_next;
  logic [N_SLAVES-1:0] one_hot;
  logic                cap_fire;
  logic                pkt_ok;
  logic [9:0]          x_new;
  logic [9:0]          y_new;
  logic [2:0]          btn_new;
  logic                unused_bits;

  assign poll_exp  = (poll_reg == '0);
  assign cnt_zero  = (cnt_reg == '0);
  assign last_slot = (cur_reg == CUR_W'(N_SLAVES - 1));
  assign one_hot   = N_SLAVES'(1);

  // Slot about to be selected: slot 0 when leaving IDLE, otherwise the next one.
  assign cur_next = (state_reg == S_IDLE) ? '0 : cur_reg + 1'b1;
  assign din_next = {6'b100000, led[{cur_next, 1'b0} +: 2]};
  assign ss_next  = ~(one_hot << cur_next);

  // Free-running poll timer; reloads on every expiry independent of en.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      poll_reg <= PW'(POLL_CYCLES - 1);
    end else if (poll_exp) begin
      poll_reg <= PW'(POLL_CYCLES - 1);
    end else begin
      poll_reg <= poll_reg - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      cur_reg   <= '0;
      ss_n      <= '1;
      snd_rec   <= 1'b0;
      din       <= 8'h80;
    end else begin
      case (state_reg)
        S_IDLE: begin
          ss_n    <= '1;
          snd_rec <= 1'b0;
          if (poll_exp && en) begin
            state_reg <= S_SELECT;
            cur_reg   <= cur_next;
            cnt_reg   <= CW'(SETUP_CYCLES - 1);
            ss_n      <= ss_next;
            din       <= din_next;
          end
        end
        S_SELECT: begin
          if (cnt_zero) begin
            state_reg <= S_TRIG;
            cnt_reg   <= CW'(TRIG_CYCLES - 1);
            snd_rec   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_TRIG: begin
          if (cnt_zero) begin
            state_reg <= S_XFER;
            cnt_reg   <= CW'(XFER_CYCLES - 1);
            snd_rec   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_XFER: begin
          if (cnt_zero) begin
            state_reg <= S_CAPTURE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_CAPTURE: begin
          state_reg <= S_GAP;
          cnt_reg   <= CW'(GAP_CYCLES - 1);
          ss_n      <= '1;
        end
        S_GAP: begin
          if (cnt_zero) begin
            if (last_slot || !en) begin
              state_reg <= S_IDLE;
            end else begin
              state_reg <= S_SELECT;
              cur_reg   <= cur_next;
              cnt_reg   <= CW'(SETUP_CYCLES - 1);
              ss_n      <= ss_next;
              din       <= din_next;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ss_n      <= '1;
          snd_rec   <= 1'b0;
        end
      endcase
    end
  end

  // Packet is latched on the edge that enters CAPTURE, so upd/err show during CAPTURE.
  assign cap_fire    = (state_reg == S_XFER) && cnt_zero;
  assign x_new       = {jstk_dout[25:24], jstk_dout[39:32]};
  assign y_new       = {jstk_dout[9:8], jstk_dout[23:16]};
  assign btn_new     = jstk_dout[2:0];
  assign pkt_ok      = ~|jstk_dout[31:26] && ~|jstk_dout[15:10];
  assign unused_bits = ^jstk_dout[7:3];

  assign miso_out = ss_n[cur_reg] ? 1'b1 : miso_in[cur_reg];

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slot
      logic       hit;
      logic [9:0] x_reg;
      logic [9:0] y_reg;
      logic [2:0] btn_reg;
      logic       upd_reg;
      logic       err_reg;

      assign hit = cap_fire && (cur_reg == CUR_W'(gi));

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          x_reg   <= '0;
          y_reg   <= '0;
          btn_reg <= '0;
          upd_reg <= 1'b0;
          err_reg <= 1'b0;
        end else begin
          upd_reg <= hit && pkt_ok;
          err_reg <= hit && !pkt_ok;
          if (hit && pkt_ok) begin
            x_reg   <= x_new;
            y_reg   <= y_new;
            btn_reg <= btn_new;
          end
        end
      end

      assign x_pos[10*gi +: 10] = x_reg;
      assign y_pos[10*gi +: 10] = y_reg;
      assign btn[3*gi +: 3]     = btn_reg;
      assign upd[gi]            = upd_reg;
      assign err[gi]            = err_reg;
    end
  endgenerate

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Bench for jstk_poll_sched: scoreboard of expected upd/err pulses plus directed timing checks.
module tb_jstk_poll_sched;

  localparam int N = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          en = 1'b1;
  logic [3:0]    led = 4'b1001;
  logic [1:0]    miso_in = 2'b00;
  logic [39:0]   jstk_dout;
  logic          miso_out;
  logic [1:0]    ss_n;
  logic          snd_rec;
  logic [7:0]    din;
  logic [19:0]   x_pos;
  logic [19:0]   y_pos;
  logic [5:0]    btn;
  logic [1:0]    upd;
  logic [1:0]    err;

  logic [39:0]   pkt0 = '0;
  logic [39:0]   pkt1 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] e_upd;
    logic [1:0] e_err;
    int         slot;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] b;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Stand-in for the SPI interface: presents the packet of whichever slave is selected.
  assign jstk_dout = ss_n[1] ? pkt0 : pkt1;

  jstk_poll_sched #(
    .N_SLAVES(N), .POLL_CYCLES(200), .SETUP_CYCLES(4),
    .TRIG_CYCLES(6), .XFER_CYCLES(20), .GAP_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .led(led), .miso_in(miso_in),
    .jstk_dout(jstk_dout), .miso_out(miso_out), .ss_n(ss_n),
    .snd_rec(snd_rec), .din(din), .x_pos(x_pos), .y_pos(y_pos),
    .btn(btn), .upd(upd), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input logic [1:0] u, input logic [1:0] e, input int s,
                      input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
    exp_t t;
    t.e_upd = u; t.e_err = e; t.slot = s; t.x = x; t.y = y; t.b = b;
    sb.push_back(t);
  endtask

  // which: 0 = ss_n[0], 1 = ss_n[1], 2 = snd_rec, other = |upd. n = posedges waited.
  task automatic wait_sig(input int which, input logic val, input int bound, output int n);
    logic s;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
      case (which)
        0:       s = ss_n[0];
        1:       s = ss_n[1];
        2:       s = snd_rec;
        default: s = |upd;
      endcase
    end while (s !== val && n < bound);
    if (s !== val) begin
      checks++;
      errors++;
      $display("FAIL timeout sig%0d: got %b expected %b after %0d cycles", which, s, val, n);
    end
  endtask

  // Monitor: every upd/err pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST && (upd != 2'b00 || err != 2'b00)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {upd, err}, 4'b0000);
      end else begin
        exp_t t;
        t = sb.pop_front();
        check($sformatf("upd_slot%0d", t.slot), upd, t.e_upd);
        check($sformatf("err_slot%0d", t.slot), err, t.e_err);
        check($sformatf("x_slot%0d", t.slot), x_pos[10*t.slot +: 10], t.x);
        check($sformatf("y_slot%0d", t.slot), y_pos[10*t.slot +: 10], t.y);
        check($sformatf("btn_slot%0d", t.slot), btn[3*t.slot +: 3], t.b);
      end
    end
  end

  // At most one slave select may be low.
  always @(negedge CLK) begin
    if (RST && ss_n != 2'b11) begin
      checks++;
      if (ss_n !== 2'b10 && ss_n !== 2'b01) begin
        errors++;
        $display("FAIL ss_overlap: got %b expected one-hot-low (cycle %0d)", ss_n, cyc);
      end
    end
  end

  initial begin
    int n;
    int t0;
    int bad;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ss_n", ss_n, 2'b11);
    check("rst_snd_rec", snd_rec, 1'b0);
    check("rst_din", din, 8'h80);
    check("rst_xyb", {x_pos, y_pos, btn}, '0);
    check("rst_upd_err", {upd, err}, 4'b0000);
    check("rst_miso_out", miso_out, 1'b1);

    // Round 1: two good packets, timing and command/MISO checks
    pkt0 = 40'h2A017F0305;
    pkt1 = 40'hFF03000002;
    push(2'b01, 2'b00, 0, 10'h12A, 10'h37F, 3'd5);
    push(2'b10, 2'b00, 1, 10'h3FF, 10'h000, 3'd2);
    @(negedge CLK);
    RST = 1'b1;
    wait_sig(0, 1'b0, 1000, n);
    check("first_select_delay", n, 200);
    t0 = cyc;
    check("din_slot0", din, 8'h81);
    miso_in = 2'b10;
    #1;
    check("miso_sel0", miso_out, 1'b0);
    wait_sig(2, 1'b1, 100, n);
    check("setup_cycles", n, 4);
    wait_sig(2, 1'b0, 100, n);
    check("trig_width", n, 6);
    wait_sig(3, 1'b1, 100, n);
    check("xfer_to_upd", n, 20);
    @(posedge CLK);
    #1;
    check("gap_ss_high", ss_n, 2'b11);
    wait_sig(1, 1'b0, 100, n);
    check("upd_to_slot1", n + 1, 5);
    check("din_slot1", din, 8'h82);
    miso_in = 2'b01;
    #1;
    check("miso_sel1", miso_out, 1'b0);
    wait_sig(1, 1'b1, 100, n);
    miso_in = 2'b00;
    #1;
    check("miso_idle", miso_out, 1'b1);

    // Round 2: slave 0 updates, slave 1 malformed keeps old values
    pkt0 = 40'h5502AA0107;
    pkt1 = 40'h11FC220001;
    push(2'b01, 2'b00, 0, 10'h255, 10'h1AA, 3'd7);
    push(2'b00, 2'b10, 1, 10'h3FF, 10'h000, 3'd2);
    wait_sig(0, 1'b0, 400, n);
    check("poll_period", cyc - t0, 200);
    wait_sig(1, 1'b0, 200, n);
    wait_sig(1, 1'b1, 200, n);

    // Round 3: drop en during slave 0 XFER
    pkt0 = 40'h8002400103;
    push(2'b01, 2'b00, 0, 10'h280, 10'h140, 3'd3);
    wait_sig(0, 1'b0, 400, n);
    wait_sig(2, 1'b1, 100, n);
    wait_sig(2, 1'b0, 100, n);
    en = 1'b0;
    wait_sig(0, 1'b1, 100, n);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK);
      #1;
      if (ss_n != 2'b11 || snd_rec) bad++;
    end
    check("idle_after_en_drop", bad, 0);
    check("sb_empty_r3", sb.size(), 0);

    // Round 4: asynchronous reset during TRIG, then a clean restart
    en = 1'b1;
    wait_sig(0, 1'b0, 400, n);
    wait_sig(2, 1'b1, 100, n);
    #1;
    RST = 1'b0;
    #1;
    check("async_rst_ss_n", ss_n, 2'b11);
    check("async_rst_snd_rec", snd_rec, 1'b0);
    check("async_rst_din", din, 8'h80);
    check("async_rst_x", x_pos, '0);
    repeat (3) @(posedge CLK);
    pkt0 = 40'h2A017F0305;
    pkt1 = 40'hFF03000002;
    push(2'b01, 2'b00, 0, 10'h12A, 10'h37F, 3'd5);
    push(2'b10, 2'b00, 1, 10'h3FF, 10'h000, 3'd2);
    @(negedge CLK);
    RST = 1'b1;
    wait_sig(0, 1'b0, 1000, n);
    check("restart_delay", n, 200);
    wait_sig(1, 1'b0, 200, n);
    wait_sig(1, 1'b1, 200, n);
    repeat (5) @(posedge CLK);
    #1;
    check("sb_empty_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "global timeout");
  end

endmodule
